// File: rtl/iccm_port_arbiter_if.sv
// Bundle of loader, fetch and SRAM-port signals shared by the ICCM port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface iccm_port_arbiter_if #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 32
);
   // Loader write path
   logic          ld_req_i;
   logic [AW-1:0] ld_addr_i;
   logic [DW-1:0] ld_wdata_i;
   logic          ld_gnt_o;

   // Fetch read path
   logic          f_req_i;
   logic [AW-1:0] f_addr_i;
   logic          f_gnt_o;
   logic [DW-1:0] f_rdata_o;
   logic          f_rvalid_o;

   // SRAM port
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_wmask_o;
   logic [DW-1:0] mem_rdata_i;

   logic [1:0]    owner_o;

   modport slave (
      input  ld_req_i, ld_addr_i, ld_wdata_i, f_req_i, f_addr_i, mem_rdata_i,
      output ld_gnt_o, f_gnt_o, f_rdata_o, f_rvalid_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, owner_o
   );

   modport master (
      output ld_req_i, ld_addr_i, ld_wdata_i, f_req_i, f_addr_i, mem_rdata_i,
      input  ld_gnt_o, f_gnt_o, f_rdata_o, f_rvalid_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, owner_o
   );
endinterface

// File: rtl/iccm_port_arbiter.sv
// Arbitrates the single-port ICCM SRAM between loader writes and fetch reads.
// Loader has priority; a starvation counter forces a fetch grant every STARVE_MAX loader wins.
module iccm_port_arbiter #(
   parameter int unsigned AW         = 12,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                clk_i,
   input logic                rst_ni,
   iccm_port_arbiter_if.slave bus
);
   localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

   typedef enum logic [1:0] {
      StNone = 2'b00,
      StLd   = 2'b01,
      StFe   = 2'b10
   } owner_e;

   owner_e          owner_q, owner_d;
   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic            rvalid_q, rvalid_d;
   logic            starved;
   logic            ld_gnt;
   logic            f_gnt;

   // Grant decision: loader wins unless fetch has waited out its budget.
   always_comb begin
      starved = bus.f_req_i && (starve_cnt_q == StarveMax);
      ld_gnt  = bus.ld_req_i && !starved;
      f_gnt   = bus.f_req_i && !ld_gnt;
   end

   // Owner FSM and starvation counter next state.
   always_comb begin
      owner_d      = StNone;
      starve_cnt_d = '0;
      rvalid_d     = f_gnt;
      unique case ({ld_gnt, f_gnt})
         2'b10:   owner_d = StLd;
         2'b01:   owner_d = StFe;
         default: owner_d = StNone;
      endcase
      if (ld_gnt && bus.f_req_i) begin
         starve_cnt_d = (starve_cnt_q == StarveMax) ? StarveMax : starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q      <= StNone;
         starve_cnt_q <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         rvalid_q     <= rvalid_d;
      end
   end

   // SRAM port and requester-facing outputs.
   always_comb begin
      bus.ld_gnt_o    = ld_gnt;
      bus.f_gnt_o     = f_gnt;
      bus.mem_req_o   = ld_gnt || f_gnt;
      bus.mem_we_o    = ld_gnt;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      bus.mem_wmask_o = '0;
      if (ld_gnt) begin
         bus.mem_addr_o  = bus.ld_addr_i;
         bus.mem_wdata_o = bus.ld_wdata_i;
         bus.mem_wmask_o = '1;
      end else if (f_gnt) begin
         bus.mem_addr_o  = bus.f_addr_i;
      end
      bus.f_rvalid_o  = rvalid_q;
      bus.f_rdata_o   = rvalid_q ? bus.mem_rdata_i : '0;
      bus.owner_o     = owner_q;
   end

   a_single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(ld_gnt && f_gnt));

   a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
      starve_cnt_q <= StarveMax);

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter with an SRAM model and a read-data scoreboard.
module tb_iccm_port_arbiter;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned SM = 4;

   logic clk_i;
   logic rst_ni;

   int checks = 0;
   int errors = 0;

   iccm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   iccm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural single-port SRAM with one-cycle read latency.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   logic [DW-1:0] sram_rdata;
   always @(posedge clk_i) begin
      if (bus.mem_req_o && bus.mem_we_o)
         sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_wmask_o) |
                                 (bus.mem_wdata_o & bus.mem_wmask_o);
      if (bus.mem_req_o && !bus.mem_we_o)
         sram_rdata <= sram[bus.mem_addr_o];
   end
   assign bus.mem_rdata_i = sram_rdata;

   logic [DW-1:0] exp_mem [int];
   logic [DW-1:0] sb [$];
   int            m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive, check combinational grant/port, then registered outputs.
   task automatic step(input logic lr, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                       input logic fr, input logic [AW-1:0] fa, output logic fg_obs);
      logic el, ef;
      logic [1:0] eo;
      logic [DW-1:0] ed;
      bus.ld_req_i   = lr;
      bus.ld_addr_i  = la;
      bus.ld_wdata_i = lw;
      bus.f_req_i    = fr;
      bus.f_addr_i   = fa;
      el = lr && !(fr && m_cnt == SM);
      ef = fr && !el;
      #1;
      fg_obs = bus.f_gnt_o;
      chk("ld_gnt", bus.ld_gnt_o, el);
      chk("f_gnt", bus.f_gnt_o, ef);
      chk("mem_req", bus.mem_req_o, el | ef);
      chk("mem_we", bus.mem_we_o, el);
      chk("mem_addr", bus.mem_addr_o, el ? la : (ef ? fa : '0));
      chk("mem_wmask", bus.mem_wmask_o, el ? 32'hFFFF_FFFF : 32'h0);
      if (!ef) chk("mem_wdata", bus.mem_wdata_o, el ? lw : '0);
      if (ef) sb.push_back(exp_mem[int'(fa)]);
      if (el) exp_mem[int'(la)] = lw;
      if (el && fr) m_cnt = (m_cnt == SM) ? SM : m_cnt + 1;
      else          m_cnt = 0;
      eo = el ? 2'b01 : (ef ? 2'b10 : 2'b00);
      @(posedge clk_i);
      #1;
      chk("owner", bus.owner_o, eo);
      chk("starve_cnt", dut.starve_cnt_q, m_cnt);
      if (sb.size() > 0) begin
         ed = sb.pop_front();
         chk("rvalid", bus.f_rvalid_o, 1'b1);
         chk("rdata", bus.f_rdata_o, ed);
      end else begin
         chk("rvalid", bus.f_rvalid_o, 1'b0);
         chk("rdata_idle", bus.f_rdata_o, 32'h0);
      end
   endtask

   initial begin
      logic fg;
      int   ld_idx;
      rst_ni         = 1'b0;
      bus.ld_req_i   = 1'b0;
      bus.ld_addr_i  = '0;
      bus.ld_wdata_i = '0;
      bus.f_req_i    = 1'b0;
      bus.f_addr_i   = '0;
      #2;
      chk("rst_rvalid", bus.f_rvalid_o, 1'b0);
      chk("rst_owner", bus.owner_o, 2'b00);
      chk("rst_mem_req", bus.mem_req_o, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Idle after reset
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, fg);

      // Loader-only burst
      for (int i = 0; i < 4; i++) step(1'b1, AW'(i), DW'(32'hA0 + i), 1'b0, '0, fg);

      // Back-to-back fetch reads, then idle to drain
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, AW'(i), fg);
      step(1'b0, '0, '0, 1'b0, '0, fg);

      // Contention: LD,LD,LD,LD,FE repeating
      ld_idx = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, AW'(12'h100 + ld_idx), DW'(32'hB0 + ld_idx), 1'b1, 12'h001, fg);
         chk("starve_pattern", fg, (i % 5) == 4);
         if (!fg) ld_idx++;
      end

      // Fetch dropping its request clears the count
      step(1'b1, 12'h200, 32'hC0, 1'b1, 12'h002, fg);
      step(1'b1, 12'h201, 32'hC1, 1'b1, 12'h002, fg);
      step(1'b1, 12'h202, 32'hC2, 1'b0, '0, fg);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, AW'(12'h203 + (i > 3 ? 3 : i)), 32'hC3, 1'b1, 12'h200, fg);
         chk("clear_pattern", fg, i == 4);
      end
      step(1'b0, '0, '0, 1'b0, '0, fg);

      // Write then read the same address on consecutive cycles
      step(1'b1, 12'h010, 32'h55, 1'b0, '0, fg);
      step(1'b0, '0, '0, 1'b1, 12'h010, fg);
      step(1'b0, '0, '0, 1'b0, '0, fg);

      // Full-width address passthrough
      step(1'b1, 12'hFFF, 32'hDEAD_BEEF, 1'b0, '0, fg);
      step(1'b0, '0, '0, 1'b1, 12'hFFF, fg);
      step(1'b0, '0, '0, 1'b0, '0, fg);

      // Reset in the cycle after a fetch grant
      bus.f_req_i  = 1'b1;
      bus.f_addr_i = 12'h010;
      #1;
      chk("pre_rst_f_gnt", bus.f_gnt_o, 1'b1);
      @(posedge clk_i);
      #1;
      bus.f_req_i = 1'b0;
      chk("pre_rst_rvalid", bus.f_rvalid_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_rvalid", bus.f_rvalid_o, 1'b0);
      chk("rst_mid_rdata", bus.f_rdata_o, 32'h0);
      chk("rst_mid_owner", bus.owner_o, 2'b00);
      chk("rst_mid_cnt", dut.starve_cnt_q, 0);
      sb.delete();
      m_cnt = 0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step(1'b1, 12'h020, 32'h77, 1'b0, '0, fg);
      step(1'b0, '0, '0, 1'b1, 12'h020, fg);
      step(1'b0, '0, '0, 1'b0, '0, fg);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
